// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with row sync and press/release debounce
// Emits rcBits = {captured rows, column strobe} for the key-update evaluator.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] rcBits,
  output logic       keyValid,
  output logic [3:0] keyIndex
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tickCnt;
  logic [DW-1:0] dbCnt;
  logic [3:0]    rowsM;
  logic [3:0]    rowsS;
  logic [3:0]    rowsCap;
  logic          tick;

  assign tick = (tickCnt == TICK_LAST);

  // Index of the lowest set bit; for a one-hot input this is its position.
  function automatic logic [1:0] lowIdx(input logic [3:0] v);
    if (v[0])      lowIdx = 2'd0;
    else if (v[1]) lowIdx = 2'd1;
    else if (v[2]) lowIdx = 2'd2;
    else if (v[3]) lowIdx = 2'd3;
    else           lowIdx = 2'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      tickCnt  <= '0;
      dbCnt    <= '0;
      rowsM    <= 4'b0000;
      rowsS    <= 4'b0000;
      rowsCap  <= 4'b0000;
      cols     <= 4'b0001;
      rcBits   <= 8'h01;
      keyValid <= 1'b0;
      keyIndex <= 4'h0;
    end else begin
      rowsM   <= rows;
      rowsS   <= rowsM;
      tickCnt <= tick ? '0 : tickCnt + 1'b1;

      if (tick) begin
        unique case (state)
          SCAN: begin
            if (rowsS == 4'b0000) begin
              cols   <= {cols[2:0], cols[3]};
              rcBits <= {4'b0000, cols[2:0], cols[3]};
            end else begin
              // Column stays put so cols still names the pressed key's column.
              rowsCap <= rowsS;
              dbCnt   <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (rowsS == rowsCap) begin
              if (dbCnt == DB_LAST) begin
                state    <= HELD;
                keyValid <= 1'b1;
                rcBits   <= {rowsCap, cols};
                keyIndex <= {lowIdx(rowsCap), lowIdx(cols)};
              end else begin
                dbCnt <= dbCnt + 1'b1;
              end
            end else begin
              state <= SCAN;
            end
          end
          HELD: begin
            if (rowsS == 4'b0000) begin
              dbCnt    <= '0;
              state    <= RELEASE;
              keyValid <= 1'b0;
              rcBits   <= {4'b0000, cols};
            end
          end
          RELEASE: begin
            if (rowsS == 4'b0000) begin
              if (dbCnt == DB_LAST) state <= SCAN;
              else                  dbCnt <= dbCnt + 1'b1;
            end else begin
              // Contact bounce on release: resume the held key as captured.
              dbCnt    <= '0;
              state    <= HELD;
              keyValid <= 1'b1;
              rcBits   <= {rowsCap, cols};
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner (SCAN_TICKS=4, DEBOUNCE_TICKS=3)
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] rcBits;
  logic       keyValid;
  logic [3:0] keyIndex;

  logic       pressed;
  logic [1:0] pr;
  logic [1:0] pc;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Keypad model: pressed key (pr,pc) shorts row pr to column pc.
  assign rows = (pressed && cols[pc]) ? (4'b0001 << pr) : 4'b0000;

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .rcBits(rcBits), .keyValid(keyValid), .keyIndex(keyIndex)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pressed = 1'b0; pr = 2'd0; pc = 2'd0;
    step(); step();
    compared++; if (cols !== 4'b0001) begin mismatched++; $display("FAIL reset_cols: got %b expected 0001", cols); end
    compared++; if (rcBits !== 8'h01) begin mismatched++; $display("FAIL reset_rcBits: got %h expected 01", rcBits); end
    compared++; if (keyValid !== 1'b0) begin mismatched++; $display("FAIL reset_keyValid: got %b expected 0", keyValid); end
    compared++; if (keyIndex !== 4'h0) begin mismatched++; $display("FAIL reset_keyIndex: got %h expected 0", keyIndex); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    logic [3:0] exp;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = 4'b0001 << ((k / 4) % 4);
      compared++; if (cols !== exp) begin mismatched++; $display("FAIL idle_cols[%0d]: got %b expected %b", k, cols, exp); end
      compared++; if (rcBits !== {4'b0000, exp}) begin mismatched++; $display("FAIL idle_rcBits[%0d]: got %h expected %h", k, rcBits, {4'b0000, exp}); end
      compared++; if (keyValid !== 1'b0) begin mismatched++; $display("FAIL idle_keyValid[%0d]: got %b expected 0", k, keyValid); end
    end
  endtask

  task automatic test_press();
    int n = 0;
    int cnt = 0;
    bit frozen = 1'b1;
    pr = 2'd2; pc = 2'd2; pressed = 1'b1;
    while (cols !== 4'b0100 && n < 40) begin step(); n++; end
    compared++; if (cols !== 4'b0100) begin mismatched++; $display("FAIL press_reach_col: got %b expected 0100", cols); end
    while (keyValid !== 1'b1 && cnt < 40) begin
      step(); cnt++;
      if (cols !== 4'b0100) frozen = 1'b0;
    end
    compared++; if (cnt != 16) begin mismatched++; $display("FAIL press_latency: got %0d expected 16", cnt); end
    compared++; if (frozen !== 1'b1) begin mismatched++; $display("FAIL press_cols_frozen: got %b expected 1", frozen); end
    compared++; if (rcBits !== 8'h44) begin mismatched++; $display("FAIL press_rcBits: got %h expected 44", rcBits); end
    compared++; if (keyIndex !== 4'hA) begin mismatched++; $display("FAIL press_keyIndex: got %h expected a", keyIndex); end
  endtask

  task automatic test_release();
    int cnt = 0;
    bit bad = 1'b0;
    pressed = 1'b0;
    while (keyValid !== 1'b0 && cnt < 20) begin step(); cnt++; end
    compared++; if (cnt != 4) begin mismatched++; $display("FAIL release_latency: got %0d expected 4", cnt); end
    compared++; if (rcBits !== 8'h04) begin mismatched++; $display("FAIL release_rcBits: got %h expected 04", rcBits); end
    compared++; if (keyIndex !== 4'hA) begin mismatched++; $display("FAIL release_keyIndex: got %h expected a", keyIndex); end
    cnt = 0;
    while (cols === 4'b0100 && cnt < 40) begin
      step(); cnt++;
      if (rcBits[7:4] !== 4'b0000 || keyValid !== 1'b0) bad = 1'b1;
    end
    compared++; if (cnt != 16) begin mismatched++; $display("FAIL release_rescan_delay: got %0d expected 16", cnt); end
    compared++; if (cols !== 4'b1000) begin mismatched++; $display("FAIL release_next_col: got %b expected 1000", cols); end
    compared++; if (rcBits !== 8'h08) begin mismatched++; $display("FAIL release_next_rcBits: got %h expected 08", rcBits); end
    compared++; if (bad !== 1'b0) begin mismatched++; $display("FAIL release_quiet: got %b expected 0", bad); end
  endtask

  task automatic test_debounce_bounce();
    int n = 0;
    int cnt = 0;
    bit sawValid = 1'b0;
    pr = 2'd1; pc = 2'd0; pressed = 1'b1;
    while (cols !== 4'b0001 && n < 20) begin step(); n++; end
    compared++; if (cols !== 4'b0001) begin mismatched++; $display("FAIL bounce_reach_col: got %b expected 0001", cols); end
    repeat (5) begin
      step(); cnt++;
      if (keyValid !== 1'b0) sawValid = 1'b1;
    end
    pressed = 1'b0;
    while (cols === 4'b0001 && cnt < 40) begin
      step(); cnt++;
      if (keyValid !== 1'b0) sawValid = 1'b1;
    end
    compared++; if (cnt != 12) begin mismatched++; $display("FAIL bounce_resume_delay: got %0d expected 12", cnt); end
    compared++; if (cols !== 4'b0010) begin mismatched++; $display("FAIL bounce_next_col: got %b expected 0010", cols); end
    compared++; if (sawValid !== 1'b0) begin mismatched++; $display("FAIL bounce_keyValid: got %b expected 0", sawValid); end
  endtask

  task automatic test_held_bounce();
    int cnt = 0;
    bit frozen = 1'b1;
    pr = 2'd1; pc = 2'd0; pressed = 1'b1;
    while (keyValid !== 1'b1 && cnt < 60) begin step(); cnt++; end
    compared++; if (cnt != 28) begin mismatched++; $display("FAIL held_press_latency: got %0d expected 28", cnt); end
    compared++; if (rcBits !== 8'h21) begin mismatched++; $display("FAIL held_rcBits: got %h expected 21", rcBits); end
    compared++; if (keyIndex !== 4'h4) begin mismatched++; $display("FAIL held_keyIndex: got %h expected 4", keyIndex); end
    pressed = 1'b0; cnt = 0;
    while (keyValid !== 1'b0 && cnt < 20) begin
      step(); cnt++;
      if (cols !== 4'b0001) frozen = 1'b0;
    end
    compared++; if (cnt != 4) begin mismatched++; $display("FAIL held_drop_latency: got %0d expected 4", cnt); end
    compared++; if (rcBits !== 8'h01) begin mismatched++; $display("FAIL held_drop_rcBits: got %h expected 01", rcBits); end
    pressed = 1'b1; cnt = 0;
    while (keyValid !== 1'b1 && cnt < 20) begin
      step(); cnt++;
      if (cols !== 4'b0001) frozen = 1'b0;
    end
    compared++; if (cnt != 4) begin mismatched++; $display("FAIL held_rebounce_latency: got %0d expected 4", cnt); end
    compared++; if (rcBits !== 8'h21) begin mismatched++; $display("FAIL held_rebounce_rcBits: got %h expected 21", rcBits); end
    compared++; if (keyIndex !== 4'h4) begin mismatched++; $display("FAIL held_rebounce_keyIndex: got %h expected 4", keyIndex); end
    compared++; if (frozen !== 1'b1) begin mismatched++; $display("FAIL held_cols_frozen: got %b expected 1", frozen); end
  endtask

  task automatic test_reset_held();
    int cnt = 0;
    reset = 1'b1;
    step();
    compared++; if (cols !== 4'b0001) begin mismatched++; $display("FAIL midreset_cols: got %b expected 0001", cols); end
    compared++; if (rcBits !== 8'h01) begin mismatched++; $display("FAIL midreset_rcBits: got %h expected 01", rcBits); end
    compared++; if (keyValid !== 1'b0) begin mismatched++; $display("FAIL midreset_keyValid: got %b expected 0", keyValid); end
    compared++; if (keyIndex !== 4'h0) begin mismatched++; $display("FAIL midreset_keyIndex: got %h expected 0", keyIndex); end
    reset = 1'b0;
    while (keyValid !== 1'b1 && cnt < 40) begin step(); cnt++; end
    compared++; if (cnt != 16) begin mismatched++; $display("FAIL redetect_latency: got %0d expected 16", cnt); end
    compared++; if (rcBits !== 8'h21) begin mismatched++; $display("FAIL redetect_rcBits: got %h expected 21", rcBits); end
    compared++; if (keyIndex !== 4'h4) begin mismatched++; $display("FAIL redetect_keyIndex: got %h expected 4", keyIndex); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press();
    test_release();
    test_debounce_bounce();
    test_held_bounce();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
